// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control unit
//
// Sequences one instruction over 2-5 cycles and shares a single memory port
// through a req/ready handshake. Traps on illegal instructions and misaligned
// accesses; the trap is sticky until reset.
//
// Optional build macro: MEM_TIMEOUT_EN - trap with cause 3 after TIMEOUT
// consecutive cycles of an unanswered memory request.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   opcode, funct    instruction fields IR[31:26], IR[5:0]
//   equal            rs == rt from the datapath
//   addr_lsb         low bits of the effective address
//   mem_ready        memory completes the current request this cycle
//   mem_req, mem_we  memory request and byte-lane write enables
//   ir_we, pc_we     instruction register / PC load strobes
//   pc_sel           0=PC+4, 1=branch target, 2=jump target
//   alu_op, alu_a_sel, alu_b_sel  ALU operation and operand selects
//   reg_d_we, reg_d_addr_sel, reg_d_data_sel  register-file write controls
//   fault, fault_cause            sticky trap flag and cause
module multicycle_control #(
  parameter int MEM_LANES = 4,
  parameter int TIMEOUT   = 16,
  localparam int LSB_W    = $clog2(MEM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 equal,
  input  logic [LSB_W-1:0]     addr_lsb,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic [MEM_LANES-1:0] mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [3:0]           alu_op,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 reg_d_we,
  output logic                 reg_d_addr_sel,
  output logic                 reg_d_data_sel,
  output logic                 fault,
  output logic [1:0]           fault_cause
);

  // ALU operation codes shared with the datapath.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  logic [2:0] state_q, state_d;
  logic [1:0] cause_q, cause_d;

  // Instruction classification
  logic is_r, is_j, is_beq, is_addi, is_lw, is_sw, is_sb, is_sh;
  logic r_legal, r_shift, legal, misaligned;
  logic [3:0] r_alu_op;

  assign is_r    = (opcode == 6'h00);
  assign is_j    = (opcode == 6'h02);
  assign is_beq  = (opcode == 6'h04);
  assign is_addi = (opcode == 6'h08);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_sb   = (opcode == 6'h28);
  assign is_sh   = (opcode == 6'h29);

  always_comb begin
    r_legal  = 1'b1;
    r_shift  = 1'b0;
    r_alu_op = ALU_ADD;
    case (funct)
      6'h20:   r_alu_op = ALU_ADD;
      6'h22:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h25:   r_alu_op = ALU_OR;
      6'h2A:   r_alu_op = ALU_SLT;
      6'h00:   begin r_alu_op = ALU_SLL; r_shift = 1'b1; end
      6'h02:   begin r_alu_op = ALU_SRL; r_shift = 1'b1; end
      6'h03:   begin r_alu_op = ALU_SRA; r_shift = 1'b1; end
      default: r_legal = 1'b0;
    endcase
  end

  assign legal = (is_r && r_legal) || is_j || is_beq || is_addi ||
                 is_lw || is_sw || is_sb || is_sh;

  assign misaligned = ((is_lw || is_sw) && (addr_lsb[1:0] != 2'b00)) ||
                      (is_sh && addr_lsb[0]);

  // Byte-lane mask for stores; on an 8-lane bus a word picks one half.
  logic [MEM_LANES-1:0] store_mask;
  always_comb begin
    store_mask = '0;
    if (is_sw) begin
      if (MEM_LANES == 4) store_mask = '1;
      else                store_mask = MEM_LANES'(4'hF) << {addr_lsb[LSB_W-1], 2'b00};
    end else if (is_sh) begin
      store_mask = MEM_LANES'(2'b11) << addr_lsb;
    end else if (is_sb) begin
      store_mask = MEM_LANES'(1'b1) << addr_lsb;
    end
  end

  logic timeout_hit;
  logic req_raw, we_ir_raw, pc_we_raw, reg_we_raw;
  logic [MEM_LANES-1:0] mem_we_raw;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic waiting;

  assign waiting     = req_raw && !mem_ready;
  // Trap on the edge where the count would reach TIMEOUT.
  assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d       = (!waiting || (state_d != state_q)) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    req_raw        = 1'b0;
    mem_we_raw     = '0;
    we_ir_raw      = 1'b0;
    pc_we_raw      = 1'b0;
    pc_sel         = 2'd0;
    alu_op         = ALU_ADD;
    alu_a_sel      = 1'b0;
    alu_b_sel      = 1'b0;
    reg_we_raw     = 1'b0;
    reg_d_addr_sel = 1'b0;
    reg_d_data_sel = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_raw = 1'b1;
        if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else if (mem_ready) begin
          we_ir_raw = 1'b1;
          pc_we_raw = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else if (is_j) begin
          pc_we_raw = 1'b1;
          pc_sel    = 2'd2;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_op    = r_alu_op;
          alu_a_sel = r_shift;
          state_d   = S_WB;
        end else if (is_addi) begin
          alu_b_sel = 1'b1;
          state_d   = S_WB;
        end else if (is_beq) begin
          alu_op    = ALU_SUB;
          pc_we_raw = equal;
          pc_sel    = 2'd1;
          state_d   = S_FETCH;
        end else begin
          alu_b_sel = 1'b1;
          if (misaligned) begin
            state_d = S_TRAP;
            cause_d = 2'd2;
          end else begin
            state_d = S_MEM;
          end
        end
      end
      S_MEM: begin
        req_raw    = 1'b1;
        alu_b_sel  = 1'b1;
        mem_we_raw = store_mask;
        if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_we_raw     = 1'b1;
        reg_d_addr_sel = is_r;
        reg_d_data_sel = is_lw;
        state_d        = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Strobes are forced low for the whole time reset is asserted.
  assign mem_req     = req_raw && rst_n;
  assign mem_we      = (req_raw && rst_n) ? mem_we_raw : '0;
  assign ir_we       = we_ir_raw && rst_n;
  assign pc_we       = pc_we_raw && rst_n;
  assign reg_d_we    = reg_we_raw && rst_n;
  assign fault       = (state_q == S_TRAP);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int LANES = 4;
  localparam int LSB_W = $clog2(LANES);
  localparam int TO    = 16;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] BAD_FN  = 4'hF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode, funct;
  logic             equal;
  logic [LSB_W-1:0] addr_lsb;
  logic             mem_ready;
  logic             mem_req;
  logic [LANES-1:0] mem_we;
  logic             ir_we, pc_we;
  logic [1:0]       pc_sel;
  logic [3:0]       alu_op;
  logic             alu_a_sel, alu_b_sel;
  logic             reg_d_we, reg_d_addr_sel, reg_d_data_sel;
  logic             fault;
  logic [1:0]       fault_cause;

  multicycle_control #(.MEM_LANES(LANES), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .equal(equal),
    .addr_lsb(addr_lsb), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .reg_d_we(reg_d_we),
    .reg_d_addr_sel(reg_d_addr_sel), .reg_d_data_sel(reg_d_data_sel),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Every output packed into one word so each cycle is a single comparison.
  logic [31:0] obs;
  assign obs = {mem_req, 7'b0, 8'(mem_we), ir_we, pc_we, pc_sel, alu_op, alu_a_sel,
                alu_b_sel, reg_d_we, reg_d_addr_sel, reg_d_data_sel, fault, fault_cause};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w(input logic req, input logic [7:0] we, input logic ir,
                                    input logic pcw, input logic [1:0] pcs, input logic [3:0] op,
                                    input logic a, input logic b, input logic rwe,
                                    input logic asel, input logic dsel, input logic flt,
                                    input logic [1:0] cause);
    return {req, 7'b0, we, ir, pcw, pcs, op, a, b, rwe, asel, dsel, flt, cause};
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20: return ALU_ADD;
      6'h22: return ALU_SUB;
      6'h24: return ALU_AND;
      6'h25: return ALU_OR;
      6'h2A: return ALU_SLT;
      6'h00: return ALU_SLL;
      6'h02: return ALU_SRL;
      6'h03: return ALU_SRA;
      default: return BAD_FN;
    endcase
  endfunction

  // One cycle: drive mem_ready away from the edge, then compare outputs.
  task automatic step(input string tag, input logic rdy, input logic [31:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check_eq(tag, obs, exp);
  endtask

  task automatic trap_cycles(input logic [1:0] cause);
    for (int i = 0; i < 10; i++)
      step("trap_hold", 1'($urandom), w(0,0,0,0,0,ALU_ADD,0,0,0,0,0,1,cause));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    check_eq("reset_outputs", obs, 32'h0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_eq("reset_held", obs, 32'h0);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("post_reset_fetch", obs, w(1,0,0,0,0,ALU_ADD,0,0,0,0,0,0,0));
  endtask

  // Expected cycle-by-cycle trace of one instruction, built from the
  // instruction's class and the stall counts.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [LSB_W-1:0] lsb, input logic eq,
                           input int sf, input int sm, output bit trapped);
    bit ok;
    int size, l;
    logic [7:0] mask;
    logic [31:0] mem_word;
    trapped = 0;
    @(posedge clk);
    #1;
    opcode = op; funct = fn; addr_lsb = lsb; equal = eq;
    for (int i = 0; i < sf; i++)
      step("fetch_wait", 1'b0, w(1,0,0,0,0,ALU_ADD,0,0,0,0,0,0,0));
    step("fetch", 1'b1, w(1,0,1,1,0,ALU_ADD,0,0,0,0,0,0,0));
    case (op)
      6'h00: ok = (alu_of(fn) != BAD_FN);
      6'h02, 6'h04, 6'h08, 6'h23, 6'h2B, 6'h28, 6'h29: ok = 1;
      default: ok = 0;
    endcase
    if (!ok) begin
      step("decode_illegal", 1'($urandom), 32'h0);
      trap_cycles(2'd1);
      trapped = 1;
      return;
    end
    if (op == 6'h02) begin
      step("decode_j", 1'($urandom), w(0,0,0,1,2,ALU_ADD,0,0,0,0,0,0,0));
      return;
    end
    step("decode", 1'($urandom), 32'h0);
    case (op)
      6'h00: begin
        step("exec_r", 1'($urandom), w(0,0,0,0,0,alu_of(fn),(fn <= 6'h03),0,0,0,0,0,0));
        step("wb_r", 1'($urandom), w(0,0,0,0,0,ALU_ADD,0,0,1,1,0,0,0));
      end
      6'h08: begin
        step("exec_addi", 1'($urandom), w(0,0,0,0,0,ALU_ADD,0,1,0,0,0,0,0));
        step("wb_addi", 1'($urandom), w(0,0,0,0,0,ALU_ADD,0,0,1,0,0,0,0));
      end
      6'h04: begin
        step("exec_beq", 1'($urandom), w(0,0,0,eq,1,ALU_SUB,0,0,0,0,0,0,0));
      end
      default: begin
        size = (op == 6'h23 || op == 6'h2B) ? 4 : (op == 6'h29) ? 2 : 1;
        l = int'(lsb);
        step("exec_mem", 1'($urandom), w(0,0,0,0,0,ALU_ADD,0,1,0,0,0,0,0));
        if (l % size != 0) begin
          trap_cycles(2'd2);
          trapped = 1;
          return;
        end
        mask = (op == 6'h23) ? 8'h00 : 8'(((1 << size) - 1) << l);
        mem_word = w(1,mask,0,0,0,ALU_ADD,0,1,0,0,0,0,0);
        for (int i = 0; i < sm; i++) step("mem_wait", 1'b0, mem_word);
        step("mem", 1'b1, mem_word);
        if (op == 6'h23)
          step("wb_lw", 1'($urandom), w(0,0,0,0,0,ALU_ADD,0,0,1,0,1,0,0));
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [5:0] op_pool [11] = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h08, 6'h23,
                               6'h2B, 6'h28, 6'h29, 6'h3F, 6'h01};
  logic [5:0] fn_pool [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A,
                               6'h00, 6'h02, 6'h03, 6'h21};

  initial begin
    bit t;
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; equal = 1'b0; addr_lsb = '0;
    do_reset();

    run_instr(6'h00, 6'h20, 2'd0, 1'b0, 0, 0, t);   // ADD
    run_instr(6'h23, 6'h00, 2'd0, 1'b0, 0, 3, t);   // LW, 3 stall cycles
    run_instr(6'h28, 6'h00, 2'd2, 1'b0, 0, 0, t);   // SB lane 2
    run_instr(6'h29, 6'h00, 2'd2, 1'b0, 0, 0, t);   // SH upper half
    run_instr(6'h2B, 6'h00, 2'd0, 1'b0, 1, 1, t);   // SW
    run_instr(6'h04, 6'h00, 2'd0, 1'b1, 0, 0, t);   // BEQ taken
    run_instr(6'h04, 6'h00, 2'd0, 1'b0, 0, 0, t);   // BEQ not taken
    run_instr(6'h02, 6'h00, 2'd0, 1'b0, 0, 0, t);   // J
    run_instr(6'h29, 6'h00, 2'd1, 1'b0, 0, 0, t);   // SH misaligned
    do_reset();
    run_instr(6'h3F, 6'h00, 2'd0, 1'b0, 0, 0, t);   // illegal opcode
    do_reset();

    for (int n = 0; n < 80; n++) begin
      run_instr(op_pool[$urandom_range(0, 10)], fn_pool[$urandom_range(0, 8)],
                LSB_W'($urandom_range(0, LANES - 1)), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), t);
      if (t) do_reset();
    end

    do_reset();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++)
      step("timeout_wait", 1'b0, w(1,0,0,0,0,ALU_ADD,0,0,0,0,0,0,0));
    step("timeout_trap", 1'b0, w(0,0,0,0,0,ALU_ADD,0,0,0,0,0,1,3));
`else
    for (int i = 0; i < 100; i++)
      step("no_timeout_fetch", 1'b0, w(1,0,0,0,0,ALU_ADD,0,0,0,0,0,0,0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
